uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO that sits behind the UART receiver and holds bytes until the host pops them.
// Define RX_FIFO_LEVEL_EN to add the `level` occupancy output.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              overrun,
    input  logic              clr_overrun
`ifdef RX_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] level
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    // Handshake: rx_valid is a one-cycle strobe with no back-pressure, so a byte
    // that meets a full FIFO is lost (overrun). rd_en is a pop request taken only
    // when not empty; the popped byte appears with rd_valid on the following cycle.

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  push, pop, drop;

    always_comb begin
        pop        = rd_en & ~empty_q;
        push       = rx_valid & (~full_q | pop);
        drop       = rx_valid & full_q & ~pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            rd_data_d = mem_q[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Flags come from the next count so they line up with the new occupancy.
        empty_d   = (count_d == '0);
        full_d    = (count_d == CNT_FULL);
        overrun_d = drop | (overrun_q & ~clr_overrun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overrun_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overrun_q  <= overrun_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is deliberately left uninitialised; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign overrun  = overrun_q;
`ifdef RX_FIFO_LEVEL_EN
    assign level    = count_q;
`endif

endmodule
